// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM row controller: row geometry, the
// controller state encoding and the byte-lane merge used on write hits.
package sdram_pkg;

  localparam int DATA_W    = 32;
  localparam int ROW_WORDS = 512;
  localparam int ROW_COUNT = 8192;
  localparam int WORD_W    = $clog2(ROW_WORDS);
  localparam int ROW_W     = $clog2(ROW_COUNT);
  localparam int ADDR_W    = ROW_W + WORD_W;

  typedef logic [ROW_WORDS-1:0][DATA_W-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    WB_ISSUE,
    WB_WAIT,
    FILL_ISSUE,
    FILL_WAIT,
    FLUSH_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0]   old_word,
    input logic [DATA_W-1:0]   new_word,
    input logic [DATA_W/8-1:0] byteenable
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (byteenable[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdram_bank_handshake.sv
// Issue/wait sequencing towards one sdram_bank: holds column and write enable
// for an operation until the bank has accepted it and then finished it.
module sdram_bank_handshake
  import sdram_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             start_we,
  input  logic [ROW_W-1:0] start_column,
  input  logic             bank_wait,
  output logic             bank_write_enable,
  output logic [ROW_W-1:0] bank_column_address,
  output logic             accept,
  output logic             done
);

  typedef enum logic [1:0] {
    H_IDLE,
    H_ISSUE,
    H_WAIT
  } phase_t;

  phase_t phase, phase_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase               <= H_IDLE;
      bank_write_enable   <= 1'b0;
      bank_column_address <= '0;
    end else begin
      phase <= phase_next;
      if (start) begin
        bank_write_enable   <= start_we;
        bank_column_address <= start_column;
      end else if (done) begin
        // Drop write mode once idle so the bank's idle samples are harmless reads.
        bank_write_enable <= 1'b0;
      end
    end
  end

  always_comb begin
    phase_next = phase;
    accept     = 1'b0;
    done       = 1'b0;
    case (phase)
      H_IDLE: begin
        if (start) phase_next = H_ISSUE;
      end
      H_ISSUE: begin
        if (!bank_wait) begin
          accept     = 1'b1;
          phase_next = H_WAIT;
        end
      end
      H_WAIT: begin
        // A chained start (write-back followed by fill) re-enters ISSUE directly.
        if (!bank_wait) begin
          done       = 1'b1;
          phase_next = start ? H_ISSUE : H_IDLE;
        end
      end
      default: phase_next = H_IDLE;
    endcase
  end

endmodule

// File: rtl/sdram_row_controller.sv
// CPU-side front end for sdram_bank: serves 32-bit word accesses from one
// locally buffered open row, writing back dirty rows and filling on misses.
module sdram_row_controller
  import sdram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  input  logic              flush,
  output logic              flush_done,
  output logic              bank_write_enable,
  output logic [ROW_W-1:0]  bank_column_address,
  input  logic              bank_wait,
  inout  wire  row_t        bank_row
);

  state_t             state, state_next;
  row_t               row_buf;
  logic [ROW_W-1:0]   buf_row;
  logic [ROW_W-1:0]   miss_row;
  logic               buf_valid;
  logic               buf_dirty;
  logic               flush_pending;
  logic               flushing;

  logic [ROW_W-1:0]   req_row;
  logic [WORD_W-1:0]  req_word;
  logic               req;
  logic               flush_req;
  logic               hit;
  logic               start;
  logic               start_we;
  logic [ROW_W-1:0]   start_column;
  logic               accept;
  logic               done;

  assign req_row   = cpu_address[ADDR_W-1:WORD_W];
  assign req_word  = cpu_address[WORD_W-1:0];
  assign req       = cpu_read | cpu_write;
  assign flush_req = flush | flush_pending;
  assign hit       = buf_valid && (buf_row == req_row) && !flush_req;

  assign cpu_waitrequest = !((state == IDLE) && hit);
  assign flush_done      = (state == FLUSH_DONE);
  assign bank_row        = bank_write_enable ? row_buf : 'z;

  always_comb begin
    cpu_readdata = '0;
    if ((state == IDLE) && hit && cpu_read) cpu_readdata = row_buf[req_word];
  end

  sdram_bank_handshake u_handshake (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .start_we            (start_we),
    .start_column        (start_column),
    .bank_wait           (bank_wait),
    .bank_write_enable   (bank_write_enable),
    .bank_column_address (bank_column_address),
    .accept              (accept),
    .done                (done)
  );

  always_comb begin
    state_next   = state;
    start        = 1'b0;
    start_we     = 1'b0;
    start_column = '0;
    case (state)
      IDLE: begin
        // A flush outranks a same-cycle CPU request, which simply stays stalled.
        if (flush_req) begin
          if (buf_dirty) begin
            start        = 1'b1;
            start_we     = 1'b1;
            start_column = buf_row;
            state_next   = WB_ISSUE;
          end else begin
            state_next = FLUSH_DONE;
          end
        end else if (req && !hit) begin
          start = 1'b1;
          if (buf_dirty) begin
            start_we     = 1'b1;
            start_column = buf_row;
            state_next   = WB_ISSUE;
          end else begin
            start_column = req_row;
            state_next   = FILL_ISSUE;
          end
        end
      end
      WB_ISSUE:   if (accept) state_next = WB_WAIT;
      WB_WAIT: begin
        if (done) begin
          if (flushing) begin
            state_next = FLUSH_DONE;
          end else begin
            start        = 1'b1;
            start_column = miss_row;
            state_next   = FILL_ISSUE;
          end
        end
      end
      FILL_ISSUE: if (accept) state_next = FILL_WAIT;
      FILL_WAIT:  if (done) state_next = IDLE;
      FLUSH_DONE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      buf_valid     <= 1'b0;
      buf_dirty     <= 1'b0;
      flush_pending <= 1'b0;
      flushing      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE)  flush_pending <= 1'b0;
      else if (flush)     flush_pending <= 1'b1;
      if ((state == IDLE) && flush_req) flushing <= 1'b1;
      else if (state == FLUSH_DONE)     flushing <= 1'b0;
      if ((state == IDLE) && hit && cpu_write) buf_dirty <= 1'b1;
      if ((state == WB_WAIT) && done)          buf_dirty <= 1'b0;
      if ((state == FILL_WAIT) && done)        buf_valid <= 1'b1;
      if (state == FLUSH_DONE)                 buf_valid <= 1'b0;
    end
  end

  // Buffer contents and row tags are qualified by buf_valid, so they need no reset.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && !flush_req && req && !hit) miss_row <= req_row;
    if ((state == IDLE) && hit && cpu_write)
      row_buf[req_word] <= byte_merge(row_buf[req_word], cpu_writedata, cpu_byteenable);
    if ((state == FILL_WAIT) && done) begin
      row_buf <= bank_row;
      buf_row <= miss_row;
    end
  end

endmodule

// File: tb/tb_sdram_row_controller.sv
// Directed bench for sdram_row_controller with a behavioural sdram_bank:
// row latency, read/write mode-change delay and periodic refresh stalls.
module tb_sdram_row_controller;
  import sdram_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              reset_bank;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_waitrequest;
  logic              flush;
  logic              flush_done;
  logic              bank_write_enable;
  logic [ROW_W-1:0]  bank_column_address;
  wire               bank_wait;
  wire  row_t        bank_row;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sdram_row_controller dut (
    .clock               (clock),
    .reset               (reset),
    .cpu_address         (cpu_address),
    .cpu_read            (cpu_read),
    .cpu_write           (cpu_write),
    .cpu_writedata       (cpu_writedata),
    .cpu_byteenable      (cpu_byteenable),
    .cpu_readdata        (cpu_readdata),
    .cpu_waitrequest     (cpu_waitrequest),
    .flush               (flush),
    .flush_done          (flush_done),
    .bank_write_enable   (bank_write_enable),
    .bank_column_address (bank_column_address),
    .bank_wait           (bank_wait),
    .bank_row            (bank_row)
  );

  // Bank model: accepts an op whenever wait is low, then stays busy for its latency.
  row_t             mem [0:15];
  row_t             bank_drive;
  logic             bank_busy;
  int               busy_cnt;
  logic             op_we;
  logic [3:0]       op_col;
  logic             prev_we;
  logic [9:0]       refresh_cnt;
  int               refresh_left;

  assign bank_wait = bank_busy | (refresh_left != 0);
  assign bank_row  = bank_write_enable ? 'z : bank_drive;

  always @(posedge clock) begin
    if (reset_bank) begin
      for (int r = 0; r < 16; r++)
        for (int w = 0; w < ROW_WORDS; w++)
          mem[r][w] <= (r >= 2) ? (32'hA500_0000 | (32'(r) << 16) | 32'(w)) : 32'h0;
      bank_drive   <= '0;
      bank_busy    <= 1'b0;
      busy_cnt     <= 0;
      op_we        <= 1'b0;
      op_col       <= '0;
      prev_we      <= 1'b0;
      refresh_cnt  <= '0;
      refresh_left <= 0;
    end else begin
      refresh_cnt <= refresh_cnt + 10'd1;
      if (refresh_cnt == 10'h3FF) refresh_left <= 12;
      else if (refresh_left != 0) refresh_left <= refresh_left - 1;
      if (!bank_wait) begin
        op_we     <= bank_write_enable;
        op_col    <= bank_column_address[3:0];
        bank_busy <= 1'b1;
        busy_cnt  <= (bank_write_enable ? 4 : 3) + ((bank_write_enable != prev_we) ? 2 : 0);
        prev_we   <= bank_write_enable;
        if (bank_write_enable) mem[bank_column_address[3:0]] <= bank_row;
      end else if (bank_busy) begin
        if (busy_cnt == 1) begin
          bank_busy <= 1'b0;
          if (!op_we) bank_drive <= mem[op_col];
        end
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd, output int waits,
                            output logic timeout);
    @(negedge clock);
    cpu_address    = a;
    cpu_read       = !wr;
    cpu_write      = wr;
    cpu_writedata  = d;
    cpu_byteenable = be;
    waits          = 0;
    timeout        = 1'b0;
    #1;
    while (cpu_waitrequest) begin
      if (waits > 300) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
      waits++;
    end
    rd = cpu_readdata;
    @(posedge clock);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          waits;
    logic        timeout;
    int          pulses;
    int          n;
    logic        we_seen;
    logic        issue_seen;
    logic        early_wait;

    reset          = 1'b1;
    reset_bank     = 1'b1;
    cpu_address    = '0;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_writedata  = '0;
    cpu_byteenable = '0;
    flush          = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_buf_valid", 32'(dut.buf_valid), 32'd0);
    check("rst_buf_dirty", 32'(dut.buf_dirty), 32'd0);
    check("rst_bank_we", 32'(bank_write_enable), 32'd0);
    check("rst_bank_col", 32'(bank_column_address), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_readdata", cpu_readdata, 32'd0);
    check("rst_waitrequest", 32'(cpu_waitrequest), 32'd1);
    reset      = 1'b0;
    reset_bank = 1'b0;

    // Cold miss on row 0
    cpu_access(1'b0, 22'h000005, 32'h0, 4'h0, rd, waits, timeout);
    check("fill0_timeout", 32'(timeout), 32'd0);
    check("fill0_stalled", 32'(waits > 0), 32'd1);
    check("fill0_data", rd, 32'h0000_0000);
    check("fill0_valid", 32'(dut.buf_valid), 32'd1);

    // Write hits and byte merge
    cpu_access(1'b1, 22'h000005, 32'hDEAD_BEEF, 4'b1111, rd, waits, timeout);
    check("wr_full_waits", 32'(waits), 32'd0);
    cpu_access(1'b0, 22'h000005, 32'h0, 4'h0, rd, waits, timeout);
    check("rd_full_waits", 32'(waits), 32'd0);
    check("rd_full_data", rd, 32'hDEAD_BEEF);
    cpu_access(1'b1, 22'h000005, 32'h0000_0011, 4'b0001, rd, waits, timeout);
    cpu_access(1'b0, 22'h000005, 32'h0, 4'h0, rd, waits, timeout);
    check("rd_byte_data", rd, 32'hDEAD_BE11);
    check("dirty_after_write", 32'(dut.buf_dirty), 32'd1);

    // Dirty miss: write-back of row 0 then fill of row 1
    cpu_access(1'b0, 22'h000200, 32'h0, 4'h0, rd, waits, timeout);
    check("wbfill_timeout", 32'(timeout), 32'd0);
    check("wbfill_stalled", 32'(waits > 0), 32'd1);
    check("wbfill_data", rd, 32'h0000_0000);
    check("wb_bank_word", mem[0][5], 32'hDEAD_BE11);
    check("wb_bank_word0", mem[0][0], 32'h0000_0000);
    check("wbfill_clean", 32'(dut.buf_dirty), 32'd0);
    check("wbfill_row", 32'(dut.buf_row), 32'd1);

    // Last word of row 1, then flush the dirty row
    cpu_access(1'b1, 22'h0003FF, 32'hCAFE_F00D, 4'b1111, rd, waits, timeout);
    check("wr_row1_waits", 32'(waits), 32'd0);
    @(negedge clock);
    flush  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      #1;
      if (flush_done) pulses++;
      @(negedge clock);
      flush = 1'b0;
    end
    check("flush_pulses", 32'(pulses), 32'd1);
    check("flush_bank_word", mem[1][511], 32'hCAFE_F00D);
    check("flush_invalid", 32'(dut.buf_valid), 32'd0);
    cpu_access(1'b0, 22'h0003FF, 32'h0, 4'h0, rd, waits, timeout);
    check("refetch_stalled", 32'(waits > 0), 32'd1);
    check("refetch_data", rd, 32'hCAFE_F00D);

    // Clean flush: no write-back, still exactly one done pulse
    @(negedge clock);
    flush   = 1'b1;
    pulses  = 0;
    we_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (flush_done) pulses++;
      if (bank_write_enable) we_seen = 1'b1;
      @(negedge clock);
      flush = 1'b0;
    end
    check("clean_flush_pulses", 32'(pulses), 32'd1);
    check("clean_flush_no_we", 32'(we_seen), 32'd0);

    // Miss issued during a refresh stall
    n = 0;
    while (refresh_left == 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("refresh_reached", 32'(refresh_left != 0), 32'd1);
    cpu_address = 22'h000405;
    cpu_read    = 1'b1;
    issue_seen  = 1'b0;
    early_wait  = 1'b0;
    n           = 0;
    #1;
    while (cpu_waitrequest && n < 300) begin
      @(negedge clock);
      #1;
      if (refresh_left != 0) begin
        if (dut.state == FILL_ISSUE) issue_seen = 1'b1;
        if (dut.state == FILL_WAIT) early_wait = 1'b1;
      end
      n++;
    end
    rd = cpu_readdata;
    @(posedge clock);
    #1;
    cpu_read = 1'b0;
    check("refresh_issue_held", 32'(issue_seen), 32'd1);
    check("refresh_no_early_wait", 32'(early_wait), 32'd0);
    check("refresh_data", rd, 32'hA502_0005);

    // Reset while a write-back is in flight
    cpu_access(1'b1, 22'h000405, 32'h1234_5678, 4'b1111, rd, waits, timeout);
    check("wr_row2_waits", 32'(waits), 32'd0);
    @(negedge clock);
    cpu_address = 22'h000605;
    cpu_read    = 1'b1;
    n           = 0;
    while (dut.state != WB_WAIT && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("reach_wb_wait", 32'(dut.state == WB_WAIT), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_waitrequest", 32'(cpu_waitrequest), 32'd1);
    check("midrst_valid", 32'(dut.buf_valid), 32'd0);
    check("midrst_bank_we", 32'(bank_write_enable), 32'd0);
    reset    = 1'b0;
    cpu_read = 1'b0;
    cpu_access(1'b0, 22'h000605, 32'h0, 4'h0, rd, waits, timeout);
    check("postrst_timeout", 32'(timeout), 32'd0);
    check("postrst_data", rd, 32'hA503_0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
